// File: rtl/frv_gf256_mul_seq.sv
// Lane-serial GF(2^8) multiply/power unit sharing one combinational multiplier across byte lanes.
// Define FRV_GF256_POW_EN to build the constant-time square-and-multiply power mode.
module frv_gf256_mul_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic               g_clk,
  input  logic               g_reset,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_op,
  input  logic [8*LANES-1:0] req_rs1,
  input  logic [8*LANES-1:0] req_rs2,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [8*LANES-1:0] rsp_data,
  output logic               busy
);

  localparam int unsigned W      = 8 * LANES;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MUL    = 3'd1;
`ifdef FRV_GF256_POW_EN
  localparam logic [2:0] S_POW_SQ = 3'd2;
  localparam logic [2:0] S_POW_ML = 3'd3;
`endif
  localparam logic [2:0] S_DONE   = 3'd4;

  // Shift-and-add over x^8+x^4+x^3+x+1; masking keeps every bit on the same path.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xs;
    p  = '0;
    xs = x;
    for (int unsigned i = 0; i < 8; i++) begin
      p  = p ^ (xs & {8{y[i]}});
      xs = {xs[6:0], 1'b0} ^ (8'h1B & {8{xs[7]}});
    end
    return p;
  endfunction

  logic [2:0]        state_q;
  logic [LANE_W-1:0] lane_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      result_q;
  logic [7:0]        a_lane;
  logic [7:0]        b_lane;
  logic [7:0]        mul_x;
  logic [7:0]        mul_y;
  logic [7:0]        mul_p;

  assign a_lane = a_q[{lane_q, 3'b000} +: 8];
  assign b_lane = b_q[{lane_q, 3'b000} +: 8];

`ifdef FRV_GF256_POW_EN
  logic [7:0] acc_q;
  logic [2:0] bit_q;
  logic       e_bit;
  logic [7:0] acc_nxt;

  assign e_bit   = b_lane[bit_q];
  assign acc_nxt = e_bit ? mul_p : acc_q;
`else
  logic unused_op;
  assign unused_op = req_op;
`endif

  always_comb begin
    mul_x = a_lane;
    mul_y = b_lane;
`ifdef FRV_GF256_POW_EN
    if (state_q == S_POW_SQ) begin
      mul_x = acc_q;
      mul_y = acc_q;
    end else if (state_q == S_POW_ML) begin
      mul_x = acc_q;
      mul_y = a_lane;
    end
`endif
  end

  assign mul_p = gf_mul(mul_x, mul_y);

  always_ff @(posedge g_clk) begin
    if (g_reset || flush) begin
      state_q  <= S_IDLE;
      lane_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
`ifdef FRV_GF256_POW_EN
      acc_q    <= 8'h01;
      bit_q    <= 3'd7;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            a_q      <= req_rs1;
            b_q      <= req_rs2;
            lane_q   <= '0;
            result_q <= '0;
`ifdef FRV_GF256_POW_EN
            acc_q    <= 8'h01;
            bit_q    <= 3'd7;
            state_q  <= req_op ? S_POW_SQ : S_MUL;
`else
            state_q  <= S_MUL;
`endif
          end
        end
        S_MUL: begin
          result_q[{lane_q, 3'b000} +: 8] <= mul_p;
          lane_q <= lane_q + LANE_W'(1);
          if (lane_q == LAST_LANE) state_q <= S_DONE;
        end
`ifdef FRV_GF256_POW_EN
        S_POW_SQ: begin
          acc_q   <= mul_p;
          state_q <= S_POW_ML;
        end
        S_POW_ML: begin
          // Multiply is always evaluated; the exponent bit only steers the mux.
          if (bit_q != 3'd0) begin
            acc_q   <= acc_nxt;
            bit_q   <= bit_q - 3'd1;
            state_q <= S_POW_SQ;
          end else begin
            result_q[{lane_q, 3'b000} +: 8] <= acc_nxt;
            lane_q  <= lane_q + LANE_W'(1);
            acc_q   <= 8'h01;
            bit_q   <= 3'd7;
            state_q <= (lane_q == LAST_LANE) ? S_DONE : S_POW_SQ;
          end
        end
`endif
        S_DONE: begin
          if (rsp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = result_q;

endmodule

// File: tb/tb_frv_gf256_mul_seq.sv
// Scoreboard bench for frv_gf256_mul_seq: reference GF model, latency, backpressure, flush and reset.
module tb_frv_gf256_mul_seq;

  localparam int unsigned LANES = 4;
`ifdef FRV_GF256_POW_EN
  localparam bit POW_EN = 1'b1;
  localparam int unsigned FLUSH_AT = 10;
`else
  localparam bit POW_EN = 1'b0;
  localparam int unsigned FLUSH_AT = 2;
`endif

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        busy;

  frv_gf256_mul_seq #(.LANES(LANES)) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [31:0] data;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_wait;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Carry-less product followed by polynomial reduction.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_pow(input logic [7:0] a, input logic [7:0] e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < int'(e); i++) r = ref_mul(r, a);
    return r;
  endfunction

  function automatic logic [31:0] ref_word(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [7:0]  x;
    logic [7:0]  y;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      x = a[8*l +: 8];
      y = b[8*l +: 8];
      r[8*l +: 8] = (POW_EN && op) ? ref_pow(x, y) : ref_mul(x, y);
    end
    return r;
  endfunction

  // Waits for idle, handshakes one request and pushes its expectation; returns on the first negedge after accept.
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
    int unsigned guard;
    exp_t e;
    guard = 0;
    while (!req_ready && guard < 200) begin
      @(negedge g_clk);
      guard++;
    end
    check("req_ready_before_issue", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    @(posedge g_clk);
    e.data = ref_word(op, a, b);
    e.lat  = (POW_EN && op) ? 16 * LANES + 1 : LANES + 1;
    sb.push_back(e);
    @(negedge g_clk);
    req_valid = 1'b0;
    req_op    = ~op;
    req_rs1   = $urandom;
    req_rs2   = $urandom;
  endtask

  task automatic wait_rsp(input string tag);
    exp_t e;
    n_wait = 1;
    while (!rsp_valid && n_wait < 400) begin
      @(negedge g_clk);
      n_wait++;
    end
    e = sb.pop_front();
    check({tag, "_lat"}, 64'(n_wait), 64'(e.lat));
    check({tag, "_data"}, rsp_data, e.data);
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    @(negedge g_clk);
    rsp_ready = 1'b0;
    check({tag, "_ready_after"}, req_ready, 1);
    check({tag, "_valid_after"}, rsp_valid, 0);
  endtask

  task automatic run(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b);
    wait_rsp(tag);
    consume(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rises;
    exp_t dropped;
    logic [31:0] held;

    @(negedge g_clk);
    @(negedge g_clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_busy", busy, 0);
    g_reset = 1'b0;
    @(negedge g_clk);

    run("mul_vec", 1'b0, 32'h0002_5753, 32'hFF80_83CA);
    run("mul_zero", 1'b0, 32'h0000_0000, 32'hFFFF_FFFF);
    run("op1_vec", 1'b1, 32'h0000_0053, 32'h0000_00CA);
    if (POW_EN) begin
      run("pow_vec", 1'b1, 32'h0300_0153, 32'h0100_FEFE);
      run("pow_zero", 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
      run("pow_one", 1'b1, 32'h0302_0153, 32'hFFFF_0000);
    end

    // Flush and request in the same cycle: request must not be taken.
    req_valid = 1'b1;
    req_rs1 = 32'h1111_1111;
    req_rs2 = 32'h2222_2222;
    flush = 1'b1;
    @(negedge g_clk);
    req_valid = 1'b0;
    flush = 1'b0;
    check("flush_vs_req_busy", busy, 0);
    check("flush_vs_req_ready", req_ready, 1);

    // Backpressure on a MUL response.
    issue(1'b0, 32'hA5C3_1F07, 32'h5A3C_E0F8);
    wait_rsp("bp");
    held = rsp_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge g_clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, held);
      check("bp_req_ready", req_ready, 0);
      check("bp_busy", busy, 1);
    end
    consume("bp");

    // Flush mid-operation.
    issue(1'b1, 32'h0300_0153, 32'h0100_FEFE);
    repeat (FLUSH_AT - 1) @(negedge g_clk);
    flush = 1'b1;
    @(negedge g_clk);
    flush = 1'b0;
    dropped = sb.pop_front();
    check("flush_req_ready", req_ready, 1);
    check("flush_rsp_valid", rsp_valid, 0);
    check("flush_rsp_data", rsp_data, 0);
    check("flush_busy", busy, 0);
    rises = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge g_clk);
      if (rsp_valid) rises++;
    end
    check("flush_no_rsp", rises, 0);
    run("post_flush_mul", 1'b0, 32'h0000_0057, 32'h0000_0083);

    // Synchronous reset mid-MUL.
    issue(1'b0, 32'h0002_5753, 32'hFF80_83CA);
    g_reset = 1'b1;
    @(negedge g_clk);
    g_reset = 1'b0;
    dropped = sb.pop_front();
    check("mrst_req_ready", req_ready, 1);
    check("mrst_rsp_valid", rsp_valid, 0);
    check("mrst_rsp_data", rsp_data, 0);
    check("mrst_busy", busy, 0);
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge g_clk);
      if (rsp_valid) rises++;
    end
    check("mrst_no_rsp", rises, 0);

    for (int i = 0; i < 6; i++)
      run("rand", (i % 3 == 2) ? 1'b1 : 1'b0, $urandom, $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
